// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 16-bit pipeline. It owns the data-memory req/ack
//   handshake, resolves branches, produces the EX forwarding value and the MEM/WB register.
// Latency: a memory op takes at least 2 cycles (IDLE, then REQ with ack). Branch and forward
//   outputs are combinational. MEM/WB is updated one edge after the stage is released.
// Backpressure: stall_mem_o holds the upstream pipeline for as long as a memory op is
//   outstanding. MEM/WB receives bubbles while the stall is active.
// Ports: clk/rst; EX/MEM inputs (*M_i); dmem_* request/response; stall_mem_o; branch_*;
//   WBResultM_o forwarding value; MEM/WB outputs (*W_o).
module mem_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IMM8_WIDTH = 8,
  parameter int REG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [IMM8_WIDTH-1:0] imm8M_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  flush_MEM_WB_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic                  stall_mem_o,
  output logic                  branch_taken_o,
  output logic [ADDR_WIDTH-1:0] branch_target_o,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic [DATA_WIDTH-1:0] ReadDataW_o,
  output logic [DATA_WIDTH-1:0] ResultAluW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  MemToRegW_o
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state, state_nxt;
  logic                  mem_op;
  logic                  acked;
  logic                  rd_done;
  logic                  req_nxt;
  logic                  we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;

  assign mem_op      = MemReadM_i | MemWriteM_i;
  // An ack only counts while a request is actually outstanding.
  assign acked       = (state == REQ) & dmem_ack_i;
  assign rd_done     = acked & ~dmem_we_o;
  assign stall_mem_o = mem_op & ~acked;

  assign branch_taken_o  = BranchM_i & (alu_outM_i == '0);
  // Unsigned sum truncated to the PC width, so targets wrap around the address space.
  assign branch_target_o = PCM_i + ADDR_WIDTH'(1) + ADDR_WIDTH'(imm8M_i);
  assign WBResultM_o     = MovM_i ? DATA_WIDTH'(imm8M_i) : alu_outM_i;

  always_comb begin
    state_nxt = state;
    req_nxt   = dmem_req_o;
    we_nxt    = dmem_we_o;
    addr_nxt  = dmem_addr_o;
    wdata_nxt = dmem_wdata_o;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          // A write takes precedence when both read and write are set.
          we_nxt    = MemWriteM_i;
          addr_nxt  = alu_outM_i[ADDR_WIDTH-1:0];
          wdata_nxt = WriteDataM_i;
        end
      end
      REQ: begin
        if (dmem_ack_i) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      state        <= state_nxt;
      dmem_req_o   <= req_nxt;
      dmem_we_o    <= we_nxt;
      dmem_addr_o  <= addr_nxt;
      dmem_wdata_o <= wdata_nxt;
    end
  end

  // MEM/WB register. A flush zeroes the register but leaves the FSM alone, so an
  // in-flight access still completes at the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadDataW_o  <= '0;
      ResultAluW_o <= '0;
      WriteRegW_o  <= '0;
      RegWriteW_o  <= 1'b0;
      MemToRegW_o  <= 1'b0;
    end else if (flush_MEM_WB_i) begin
      ReadDataW_o  <= '0;
      ResultAluW_o <= '0;
      WriteRegW_o  <= '0;
      RegWriteW_o  <= 1'b0;
      MemToRegW_o  <= 1'b0;
    end else if (stall_mem_o) begin
      RegWriteW_o  <= 1'b0;
      MemToRegW_o  <= 1'b0;
    end else begin
      if (rd_done) ReadDataW_o <= dmem_rdata_i;
      ResultAluW_o <= WBResultM_o;
      WriteRegW_o  <= WriteRegM_i;
      RegWriteW_o  <= RegWriteM_i;
      MemToRegW_o  <= MemToRegM_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with hand-computed expected values.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 2 units after the edge.
// Ports: none (top-level bench).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  PCM_i = '0;
  logic [15:0] WriteDataM_i = '0;
  logic [7:0]  imm8M_i = '0;
  logic [3:0]  WriteRegM_i = '0;
  logic [15:0] alu_outM_i = '0;
  logic        RegWriteM_i = 1'b0, BranchM_i = 1'b0, MemReadM_i = 1'b0;
  logic        MemWriteM_i = 1'b0, MemToRegM_i = 1'b0, MovM_i = 1'b0;
  logic        flush_MEM_WB_i = 1'b0;
  logic [15:0] dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic        dmem_req_o, dmem_we_o, stall_mem_o, branch_taken_o;
  logic [7:0]  dmem_addr_o, branch_target_o;
  logic [15:0] dmem_wdata_o, WBResultM_o, ReadDataW_o, ResultAluW_o;
  logic [3:0]  WriteRegW_o;
  logic        RegWriteW_o, MemToRegW_o;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .PCM_i(PCM_i), .WriteDataM_i(WriteDataM_i), .imm8M_i(imm8M_i),
    .WriteRegM_i(WriteRegM_i), .alu_outM_i(alu_outM_i),
    .RegWriteM_i(RegWriteM_i), .BranchM_i(BranchM_i), .MemReadM_i(MemReadM_i),
    .MemWriteM_i(MemWriteM_i), .MemToRegM_i(MemToRegM_i), .MovM_i(MovM_i),
    .flush_MEM_WB_i(flush_MEM_WB_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .stall_mem_o(stall_mem_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o), .WBResultM_o(WBResultM_o),
    .ReadDataW_o(ReadDataW_o), .ResultAluW_o(ResultAluW_o),
    .WriteRegW_o(WriteRegW_o), .RegWriteW_o(RegWriteW_o), .MemToRegW_o(MemToRegW_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge so that new inputs can be applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    RegWriteM_i = 0; BranchM_i = 0; MemReadM_i = 0; MemWriteM_i = 0;
    MemToRegM_i = 0; MovM_i = 0; flush_MEM_WB_i = 0; dmem_ack_i = 0;
  endtask

  task automatic check_wb_zero(input string tag);
    check_eq({tag, "_rdw"}, 32'(ReadDataW_o), 32'h0);
    check_eq({tag, "_alw"}, 32'(ResultAluW_o), 32'h0);
    check_eq({tag, "_wrw"}, 32'(WriteRegW_o), 32'h0);
    check_eq({tag, "_rgw"}, 32'(RegWriteW_o), 32'h0);
    check_eq({tag, "_m2r"}, 32'(MemToRegW_o), 32'h0);
  endtask

  initial begin
    // Test 1: reset pulse between edges forces outputs low before any edge.
    #2 rst = 1;
    #2;
    check_eq("rst_req", 32'(dmem_req_o), 32'h0);
    check_eq("rst_we", 32'(dmem_we_o), 32'h0);
    check_eq("rst_addr", 32'(dmem_addr_o), 32'h0);
    check_eq("rst_wdata", 32'(dmem_wdata_o), 32'h0);
    check_wb_zero("rst");
    #4 rst = 0;

    // Test 2: load with ack three cycles after the request.
    next_cycle();
    MemReadM_i = 1; alu_outM_i = 16'h0023; RegWriteM_i = 1; MemToRegM_i = 1; WriteRegM_i = 4'd5;
    #1;
    check_eq("ld_stall0", 32'(stall_mem_o), 32'h1);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      check_eq("ld_req", 32'(dmem_req_o), 32'h1);
      check_eq("ld_addr", 32'(dmem_addr_o), 32'h23);
      check_eq("ld_we", 32'(dmem_we_o), 32'h0);
      check_eq("ld_stall", 32'(stall_mem_o), 32'h1);
      check_eq("ld_bubble", 32'(RegWriteW_o), 32'h0);
    end
    next_cycle();
    dmem_ack_i = 1; dmem_rdata_i = 16'hBEEF;
    #1;
    check_eq("ld_ack_req", 32'(dmem_req_o), 32'h1);
    check_eq("ld_ack_addr", 32'(dmem_addr_o), 32'h23);
    check_eq("ld_ack_stall", 32'(stall_mem_o), 32'h0);
    next_cycle();
    clear_ctrl(); dmem_rdata_i = 16'h0000;
    #1;
    check_eq("ld_rdw", 32'(ReadDataW_o), 32'hBEEF);
    check_eq("ld_wrw", 32'(WriteRegW_o), 32'h5);
    check_eq("ld_rgw", 32'(RegWriteW_o), 32'h1);
    check_eq("ld_m2r", 32'(MemToRegW_o), 32'h1);
    check_eq("ld_done_req", 32'(dmem_req_o), 32'h0);

    // Test 3: store, then load immediately, each acked in its first REQ cycle.
    MemWriteM_i = 1; alu_outM_i = 16'h0040; WriteDataM_i = 16'h1234;
    #1;
    check_eq("st_stall0", 32'(stall_mem_o), 32'h1);
    next_cycle();
    dmem_ack_i = 1;
    #1;
    check_eq("st_req", 32'(dmem_req_o), 32'h1);
    check_eq("st_we", 32'(dmem_we_o), 32'h1);
    check_eq("st_addr", 32'(dmem_addr_o), 32'h40);
    check_eq("st_wdata", 32'(dmem_wdata_o), 32'h1234);
    check_eq("st_stall1", 32'(stall_mem_o), 32'h0);
    next_cycle();
    clear_ctrl();
    MemReadM_i = 1; alu_outM_i = 16'h0041; RegWriteM_i = 1; MemToRegM_i = 1; WriteRegM_i = 4'd7;
    #1;
    check_eq("b2b_req_gap", 32'(dmem_req_o), 32'h0);
    check_eq("b2b_stall0", 32'(stall_mem_o), 32'h1);
    check_eq("st_alw", 32'(ResultAluW_o), 32'h40);
    check_eq("st_rgw", 32'(RegWriteW_o), 32'h0);
    check_eq("st_rdw_hold", 32'(ReadDataW_o), 32'hBEEF);
    next_cycle();
    dmem_ack_i = 1; dmem_rdata_i = 16'h5678;
    #1;
    check_eq("b2b_req", 32'(dmem_req_o), 32'h1);
    check_eq("b2b_we", 32'(dmem_we_o), 32'h0);
    check_eq("b2b_addr", 32'(dmem_addr_o), 32'h41);
    check_eq("b2b_stall1", 32'(stall_mem_o), 32'h0);
    next_cycle();
    clear_ctrl();
    #1;
    check_eq("b2b_rdw", 32'(ReadDataW_o), 32'h5678);
    check_eq("b2b_wrw", 32'(WriteRegW_o), 32'h7);
    check_eq("b2b_rgw", 32'(RegWriteW_o), 32'h1);

    // Test 4: branch resolution with target wrap-around.
    BranchM_i = 1; alu_outM_i = 16'h0000; PCM_i = 8'hFE; imm8M_i = 8'h03;
    #1;
    check_eq("br_taken", 32'(branch_taken_o), 32'h1);
    check_eq("br_target", 32'(branch_target_o), 32'h02);
    alu_outM_i = 16'h0001;
    #1;
    check_eq("br_not_taken", 32'(branch_taken_o), 32'h0);
    BranchM_i = 0; alu_outM_i = 16'h0000;
    #1;
    check_eq("br_no_branch", 32'(branch_taken_o), 32'h0);

    // Test 5: MOV forwards the zero-extended immediate.
    next_cycle();
    MovM_i = 1; imm8M_i = 8'h9C; alu_outM_i = 16'h1111; RegWriteM_i = 1; WriteRegM_i = 4'd3;
    #1;
    check_eq("mov_fwd", 32'(WBResultM_o), 32'h009C);
    next_cycle();
    MovM_i = 0;
    #1;
    check_eq("mov_alw", 32'(ResultAluW_o), 32'h009C);
    check_eq("mov_wrw", 32'(WriteRegW_o), 32'h3);
    check_eq("alu_fwd", 32'(WBResultM_o), 32'h1111);

    // A flush overrides a valid instruction.
    flush_MEM_WB_i = 1;
    next_cycle();
    clear_ctrl();
    #1;
    check_wb_zero("flush");

    // Test 6: reset during REQ drops the request; a late ack is ignored.
    MemReadM_i = 1; alu_outM_i = 16'h0055; RegWriteM_i = 1; MemToRegM_i = 1; WriteRegM_i = 4'd9;
    next_cycle(); #1;
    check_eq("rr_req", 32'(dmem_req_o), 32'h1);
    #1 rst = 1;
    clear_ctrl();
    #1;
    check_eq("rr_req_drop", 32'(dmem_req_o), 32'h0);
    check_eq("rr_addr", 32'(dmem_addr_o), 32'h0);
    #2 rst = 0;
    next_cycle();
    dmem_ack_i = 1; dmem_rdata_i = 16'hDEAD;
    #1;
    check_eq("rr_stall", 32'(stall_mem_o), 32'h0);
    next_cycle();
    dmem_ack_i = 0;
    #1;
    check_eq("rr_req_idle", 32'(dmem_req_o), 32'h0);
    check_eq("rr_rdw", 32'(ReadDataW_o), 32'h0);
    check_eq("rr_rgw", 32'(RegWriteW_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 16-bit pipelined processor: the consumer of the EX/MEM pipeline register.
- Accesses data memory through a registered req/ack handshake and resolves branches.
- Produces the forwarded value WBResultM for EX and the MEM/WB pipeline register.
- Stalls the upstream pipeline while a data-memory access is outstanding.

Parameters:
DATA_WIDTH, 16, datapath / memory word width
ADDR_WIDTH, 8, PC and data-memory address width
IMM8_WIDTH, 8, immediate width
REG_WIDTH, 4, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
PCM_i  input  ADDR_WIDTH  PC of instruction in MEM
WriteDataM_i  input  DATA_WIDTH  store data
imm8M_i  input  IMM8_WIDTH  immediate (branch offset / MOV value)
WriteRegM_i  input  REG_WIDTH  destination register
alu_outM_i  input  DATA_WIDTH  ALU result / memory address
RegWriteM_i, BranchM_i, MemReadM_i, MemWriteM_i, MemToRegM_i, MovM_i  input  1 each  control vector
flush_MEM_WB_i  input  1  load bubble into MEM/WB
dmem_req_o  output  1  memory request (registered)
dmem_we_o  output  1  1 = write, 0 = read
dmem_addr_o  output  ADDR_WIDTH  alu_outM_i[ADDR_WIDTH-1:0], held during request
dmem_wdata_o  output  DATA_WIDTH  store data, held during request
dmem_rdata_i  input  DATA_WIDTH  read data, valid with ack
dmem_ack_i  input  1  one-cycle access completion
stall_mem_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
branch_taken_o  output  1  combinational branch resolution
branch_target_o  output  ADDR_WIDTH  branch destination
WBResultM_o  output  DATA_WIDTH  forwarding value for EX
ReadDataW_o  output  DATA_WIDTH  MEM/WB load data
ResultAluW_o  output  DATA_WIDTH  MEM/WB non-load result
WriteRegW_o  output  REG_WIDTH  MEM/WB destination
RegWriteW_o, MemToRegW_o  output  1 each  MEM/WB control

Behaviour:
- mem_op = MemReadM_i | MemWriteM_i. If both are set, treat as a write.
- FSM states: IDLE, REQ. Reset enters IDLE.
  - IDLE: if mem_op -> REQ. At the same edge, dmem_req_o<=1, dmem_we_o<=MemWriteM_i, and address/wdata are latched.
  - REQ: dmem_req_o stays 1 and address/data stay stable until dmem_ack_i.
  - REQ on ack: dmem_req_o<=0 -> IDLE.
  - dmem_ack_i in IDLE is ignored.
- stall_mem_o = mem_op & ~(state==REQ & dmem_ack_i), combinational. Minimum memory-op latency is 2 cycles (IDLE, REQ+ack). A back-to-back memory op re-enters REQ on the next cycle.
- Branch: branch_taken_o = BranchM_i & (alu_outM_i==0). branch_target_o = PCM_i + 1 + imm8M_i, modulo 2^ADDR_WIDTH (wraps, unsigned).
- WBResultM_o = MovM_i ? zero-extended imm8M_i : alu_outM_i.
- MEM/WB register, posedge clk, priority order:
  1. rst (async): all MEM/WB outputs 0.
  2. flush_MEM_WB_i: all MEM/WB outputs 0.
  3. stall_mem_o: bubble; RegWriteW_o<=0, MemToRegW_o<=0, other fields hold.
  4. else: ReadDataW_o<=dmem_rdata_i if (state==REQ & ack & ~dmem_we_o), otherwise hold; ResultAluW_o<=WBResultM_o; WriteRegW_o<=WriteRegM_i; RegWriteW_o<=RegWriteM_i; MemToRegW_o<=MemToRegM_i.
- Reset values: dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, all MEM/WB outputs 0, FSM=IDLE.
- Reset asserted mid-request: request is dropped immediately and the FSM returns to IDLE. A late ack is ignored.
- Flush during REQ: the access still completes (the memory side effect is kept). The MEM/WB register takes the bubble.

Test Plan:
1. Reset: rst pulses between clock edges -> all outputs 0 immediately, before the next clk edge.
2. Load: MemReadM_i=1, alu_outM_i=16'h0023, RegWriteM=1, MemToRegM=1, WriteRegM=5; memory acks 3 cycles after req with rdata=16'hBEEF -> dmem_addr_o=8'h23 is held stable; stall_mem_o=1 up to the ack cycle; next edge gives ReadDataW_o=16'hBEEF, WriteRegW_o=5, RegWriteW_o=1; bubbles (RegWriteW_o=0) during the stall.
3. Store, then immediate load, with ack in the same cycle as REQ -> we=1 with wdata=WriteDataM_i; stall is exactly 1 cycle per op; req re-asserts 1 cycle after the first ack.
4. Branch: BranchM_i=1, alu_outM_i=0, PCM_i=8'hFE, imm8=8'h03 -> branch_taken_o=1, branch_target_o=8'h02 (wrap). With alu_outM_i=1 -> branch_taken_o=0.
5. MOV: MovM_i=1, imm8=8'h9C -> WBResultM_o=16'h009C; ResultAluW_o=16'h009C next edge.
6. rst asserted during REQ, with ack arriving one cycle after release -> dmem_req_o=0 immediately, FSM in IDLE, ack ignored, no MEM/WB write.
